// File: rtl/exec_stage.sv
// Execute stage: operand-B select, ALU-control decode, single-cycle ALU with a
// registered result, plus an iterative multiply/divide unit that writes HI/LO
// and stalls the issue side through a valid/ready handshake.
module exec_stage #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alu_src,
  input  logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic [WIDTH-1:0]   imm,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [FUNCT_W-1:0] inst_i,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [W2-1:0]    ONE_2W   = W2'(1);

  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'h20);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'h22);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'h24);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'h25);
  localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'(6'h26);
  localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'(6'h27);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'h2A);
  localparam logic [FUNCT_W-1:0] F_SLTU  = FUNCT_W'(6'h2B);
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'h00);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(6'h02);
  localparam logic [FUNCT_W-1:0] F_SRA   = FUNCT_W'(6'h03);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'h10);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'h12);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'h18);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'h19);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'h1A);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'h1B);

  localparam logic [FUNCT_W-1:0] I_ADDI  = FUNCT_W'(6'h08);
  localparam logic [FUNCT_W-1:0] I_SLTI  = FUNCT_W'(6'h0A);
  localparam logic [FUNCT_W-1:0] I_ANDI  = FUNCT_W'(6'h0C);
  localparam logic [FUNCT_W-1:0] I_ORI   = FUNCT_W'(6'h0D);
  localparam logic [FUNCT_W-1:0] I_XORI  = FUNCT_W'(6'h0E);
  localparam logic [FUNCT_W-1:0] I_LUI   = FUNCT_W'(6'h0F);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_UNDEF
  } op_t;

  // Magnitude of a value when interpreted as signed; raw value otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) return ~v + ONE_W;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;   // MUL: product high half; DIV: partial remainder
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;   // MUL: multiplier/product low; DIV: dividend/quotient
  logic [WIDTH-1:0]  opb_q, opb_d;         // multiplicand or divisor magnitude
  logic              qneg_q, qneg_d;       // negate product / quotient at completion
  logic              rneg_q, rneg_d;       // negate remainder at completion
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;

  op_t                      op;
  logic [WIDTH-1:0]         op_b;
  logic signed [WIDTH-1:0]  a_s, b_s;
  logic [SHW-1:0]           shamt;
  logic [WIDTH-1:0]         alu_res;
  logic                     sgn_op;

  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_prod, mul_fix;
  logic [WIDTH:0]    div_shift, div_trial;
  logic              div_ok;
  logic [WIDTH-1:0]  div_rem, div_quo;

  assign op_b  = alu_src ? imm : data2;
  assign a_s   = data1;
  assign b_s   = op_b;
  assign shamt = op_b[SHW-1:0];

  // Map alu_op/funct/inst_i onto a single internal operation code.
  always_comb begin
    op = OP_UNDEF;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct)
          F_ADD:   op = OP_ADD;
          F_SUB:   op = OP_SUB;
          F_AND:   op = OP_AND;
          F_OR:    op = OP_OR;
          F_XOR:   op = OP_XOR;
          F_NOR:   op = OP_NOR;
          F_SLT:   op = OP_SLT;
          F_SLTU:  op = OP_SLTU;
          F_SLL:   op = OP_SLL;
          F_SRL:   op = OP_SRL;
          F_SRA:   op = OP_SRA;
          F_MFHI:  op = OP_MFHI;
          F_MFLO:  op = OP_MFLO;
          F_MULT:  op = OP_MULT;
          F_MULTU: op = OP_MULTU;
          F_DIV:   op = OP_DIV;
          F_DIVU:  op = OP_DIVU;
          default: op = OP_UNDEF;
        endcase
      end
      default: begin
        case (inst_i)
          I_ADDI:  op = OP_ADD;
          I_SLTI:  op = OP_SLT;
          I_ANDI:  op = OP_AND;
          I_ORI:   op = OP_OR;
          I_XORI:  op = OP_XOR;
          I_LUI:   op = OP_LUI;
          default: op = OP_UNDEF;
        endcase
      end
    endcase
  end

  // Single-cycle ALU; HI/LO reads see the registers as they stand at issue.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = data1 + op_b;
      OP_SUB:  alu_res = data1 - op_b;
      OP_AND:  alu_res = data1 & op_b;
      OP_OR:   alu_res = data1 | op_b;
      OP_XOR:  alu_res = data1 ^ op_b;
      OP_NOR:  alu_res = ~(data1 | op_b);
      OP_SLT:  alu_res = (a_s < b_s) ? ONE_W : '0;
      OP_SLTU: alu_res = (data1 < op_b) ? ONE_W : '0;
      OP_SLL:  alu_res = data1 << shamt;
      OP_SRL:  alu_res = data1 >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_LUI:  alu_res = op_b << 16;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step per cycle.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    mul_prod  = {mul_sum, acc_lo_q[WIDTH-1:1]};
    mul_fix   = qneg_q ? neg_2w(mul_prod) : mul_prod;
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_ok    = ~div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo   = {acc_lo_q[WIDTH-2:0], div_ok};
  end

  // Control FSM and next-state of all registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opb_d       = opb_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    sgn_op      = (op == OP_MULT) || (op == OP_DIV);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_hi_d = '0;
              acc_lo_d = mag(data1, sgn_op);
              opb_d    = mag(op_b, sgn_op);
              qneg_d   = sgn_op & (data1[WIDTH-1] ^ op_b[WIDTH-1]);
              rneg_d   = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (op_b == '0) begin
                lo_d        = '1;
                hi_d        = data1;
                result_d    = '1;
                zero_d      = 1'b0;
                out_valid_d = 1'b1;
              end else begin
                acc_hi_d = '0;
                acc_lo_d = mag(data1, sgn_op);
                opb_d    = mag(op_b, sgn_op);
                qneg_d   = sgn_op & (data1[WIDTH-1] ^ op_b[WIDTH-1]);
                rneg_d   = sgn_op & data1[WIDTH-1];
                cnt_d    = '0;
                state_d  = S_DIV;
              end
            end
            default: begin
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_hi_d = mul_prod[W2-1:WIDTH];
        acc_lo_d = mul_prod[WIDTH-1:0];
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d        = mul_fix[W2-1:WIDTH];
          lo_d        = mul_fix[WIDTH-1:0];
          result_d    = mul_fix[WIDTH-1:0];
          zero_d      = (mul_fix[WIDTH-1:0] == '0);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DIV: begin
        acc_hi_d = div_rem;
        acc_lo_d = div_quo;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d        = rneg_q ? neg_w(div_rem) : div_rem;
          lo_d        = qneg_q ? neg_w(div_quo) : div_quo;
          result_d    = qneg_q ? neg_w(div_quo) : div_quo;
          zero_d      = (div_quo == '0);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multi-cycle operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opb_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opb_q       <= opb_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed testbench for exec_stage: reset, single-cycle ALU ops, I-type ops,
// multiply, divide, divide-by-zero, HI/LO moves and reset during a divide.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [31:0] data1, data2, imm;
  logic [5:0]  funct, inst_i;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  exec_stage #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src(alu_src), .alu_op(alu_op), .data1(data1), .data2(data2),
    .imm(imm), .funct(funct), .inst_i(inst_i), .out_valid(out_valid),
    .result(result), .zero(zero), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present one operation at the falling edge; return 1 time unit after it is taken.
  task automatic issue(input logic [1:0] op, input logic src, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] im,
                       input logic [5:0] f, input logic [5:0] ii);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; alu_src = src;
    data1 = d1; data2 = d2; imm = im; funct = f; inst_i = ii;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait until in_ready returns, counting stalled cycles and stray out_valid pulses.
  task automatic wait_done(output int stall, output int stray);
    stall = 0; stray = 0;
    while (in_ready !== 1'b1 && stall < 200) begin
      if (out_valid === 1'b1) stray++;
      stall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; alu_src = 1'b0; alu_op = 2'b00;
    data1 = '0; data2 = '0; imm = '0; funct = '0; inst_i = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
    vectors++; if ({result, hi, lo} !== 96'h0) begin miscompares++; $display("FAIL rel_regs: got %h %h %h want 0", result, hi, lo); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL rel_zero: got %b want 0", zero); end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn [12];
    logic [31:0] a  [12];
    logic [31:0] b  [12];
    logic [31:0] ex [12];
    fn = '{6'h22, 6'h20, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F};
    a  = '{32'd5, 32'hFFFFFFFF, 32'hF0F01234, 32'h000000F0, 32'hFFFF0000, 32'h0,
           32'hFFFFFFFD, 32'hFFFFFFFD, 32'h1, 32'h80000000, 32'h80000000, 32'h12345678};
    b  = '{32'd7, 32'h1, 32'h0FF0FFFF, 32'h0000000F, 32'h0F0F0F0F, 32'h0,
           32'h2, 32'h2, 32'h4, 32'd31, 32'h4, 32'h1};
    ex = '{32'hFFFFFFFE, 32'h0, 32'h00F01234, 32'h000000FF, 32'hF0F00F0F, 32'hFFFFFFFF,
           32'h1, 32'h0, 32'h10, 32'h1, 32'hF8000000, 32'h0};
    for (int i = 0; i < 12; i++) begin
      issue(2'b10, 1'b0, a[i], b[i], 32'h0, fn[i], 6'h0);
      vectors++; if (result !== ex[i]) begin miscompares++; $display("FAIL rtype_result[%0d]: got %h want %h", i, result, ex[i]); end
      vectors++; if (zero !== (ex[i] == 32'h0)) begin miscompares++; $display("FAIL rtype_zero[%0d]: got %b want %b", i, zero, ex[i] == 32'h0); end
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rtype_handshake[%0d]: got ov=%b rdy=%b want 1 1", i, out_valid, in_ready); end
    end
    issue(2'b00, 1'b1, 32'd100, 32'h0, 32'hFFFFFFFF, 6'h0, 6'h0);
    vectors++; if (result !== 32'd99) begin miscompares++; $display("FAIL aluop_add: got %h want %h", result, 32'd99); end
    issue(2'b01, 1'b0, 32'd10, 32'd10, 32'h0, 6'h0, 6'h0);
    vectors++; if (result !== 32'h0 || zero !== 1'b1) begin miscompares++; $display("FAIL aluop_sub: got %h z=%b want 0 z=1", result, zero); end
    idle();
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rtype_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_itype();
    issue(2'b11, 1'b1, 32'h0, 32'h0, 32'h00001234, 6'h0, 6'h0F);
    vectors++; if (result !== 32'h12340000) begin miscompares++; $display("FAIL lui: got %h want %h", result, 32'h12340000); end
    issue(2'b11, 1'b1, 32'hFFFFFFFD, 32'h0, 32'h2, 6'h0, 6'h0A);
    vectors++; if (result !== 32'h1) begin miscompares++; $display("FAIL slti: got %h want 1", result); end
    issue(2'b11, 1'b1, 32'h000000F0, 32'hFFFFFFFF, 32'h00000F00, 6'h0, 6'h0D);
    vectors++; if (result !== 32'h00000FF0) begin miscompares++; $display("FAIL ori: got %h want %h", result, 32'h00000FF0); end
    issue(2'b11, 1'b1, 32'd5, 32'h0, 32'hFFFFFFFF, 6'h0, 6'h08);
    vectors++; if (result !== 32'd4) begin miscompares++; $display("FAIL addi: got %h want 4", result); end
    issue(2'b11, 1'b1, 32'd5, 32'h0, 32'd5, 6'h0, 6'h3F);
    vectors++; if (result !== 32'h0 || zero !== 1'b1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL itype_undef: got %h z=%b ov=%b want 0 1 1", result, zero, out_valid); end
    idle();
  endtask

  task automatic test_mult();
    int stall, stray;
    issue(2'b10, 1'b0, 32'hFFFFFFFA, 32'd7, 32'h0, 6'h18, 6'h0);
    // Keep presenting a different op while busy; it must be ignored.
    data1 = 32'd1; data2 = 32'd1; funct = 6'h20;
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mult_start: got busy=%b rdy=%b want 1 0", busy, in_ready); end
    wait_done(stall, stray);
    vectors++; if (stall !== 32) begin miscompares++; $display("FAIL mult_stall: got %0d want 32", stall); end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL mult_stray_valid: got %0d want 0", stray); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mult_valid: got %b want 1", out_valid); end
    vectors++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6) begin miscompares++; $display("FAIL mult_hilo: got %h %h want ffffffff ffffffd6", hi, lo); end
    vectors++; if (result !== 32'hFFFFFFD6) begin miscompares++; $display("FAIL mult_result: got %h want ffffffd6", result); end
    idle();
    issue(2'b10, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h0, 6'h19, 6'h0);
    idle();
    wait_done(stall, stray);
    vectors++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE || stall !== 32) begin miscompares++; $display("FAIL multu: got %h %h stall=%0d want 1 fffffffe 32", hi, lo, stall); end
    issue(2'b10, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 6'h18, 6'h0);
    idle();
    wait_done(stall, stray);
    vectors++; if (hi !== 32'h40000000 || lo !== 32'h0 || zero !== 1'b1) begin miscompares++; $display("FAIL mult_minmin: got %h %h z=%b want 40000000 0 1", hi, lo, zero); end
  endtask

  task automatic test_div();
    int stall, stray;
    issue(2'b10, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h0, 6'h1A, 6'h0);
    idle();
    wait_done(stall, stray);
    vectors++; if (stall !== 32 || out_valid !== 1'b1) begin miscompares++; $display("FAIL div_timing: got stall=%0d ov=%b want 32 1", stall, out_valid); end
    vectors++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_neg: got lo=%h hi=%h want fffffffd ffffffff", lo, hi); end
    issue(2'b10, 1'b0, 32'd100, 32'd7, 32'h0, 6'h1B, 6'h0);
    idle();
    wait_done(stall, stray);
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL divu: got lo=%h hi=%h want e 2", lo, hi); end
    issue(2'b10, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 6'h1A, 6'h0);
    idle();
    wait_done(stall, stray);
    vectors++; if (lo !== 32'h80000000 || hi !== 32'h0) begin miscompares++; $display("FAIL div_minneg: got lo=%h hi=%h want 80000000 0", lo, hi); end
    issue(2'b10, 1'b0, 32'd9, 32'd0, 32'h0, 6'h1A, 6'h0);
    vectors++; if (lo !== 32'hFFFFFFFF || hi !== 32'd9) begin miscompares++; $display("FAIL div0_hilo: got lo=%h hi=%h want ffffffff 9", lo, hi); end
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL div0_ctrl: got ov=%b rdy=%b busy=%b want 1 1 0", out_valid, in_ready, busy); end
    issue(2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 6'h10, 6'h0);
    vectors++; if (result !== 32'd9) begin miscompares++; $display("FAIL mfhi: got %h want 9", result); end
    issue(2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 6'h12, 6'h0);
    vectors++; if (result !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mflo: got %h want ffffffff", result); end
    idle();
  endtask

  task automatic test_reset_mid_div();
    int seen;
    issue(2'b10, 1'b0, 32'd100, 32'd7, 32'h0, 6'h1B, 6'h0);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rdiv_busy: got %b want 1", busy); end
    @(negedge clk); rst = 1'b1;
    #1;
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL rdiv_hilo: got %h %h want 0 0", hi, lo); end
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rdiv_abort: got busy=%b ov=%b want 0 0", busy, out_valid); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rdiv_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (40) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rdiv_no_valid: got %0d pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_mult();
    test_div();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
